hash_arbiter: RTL and testbench

HASH_ARBITER -- requirements
Module: hash_arbiter

---
 rtl/hash_arbiter.sv | 125 ++++++++++++
 tb/tb_hash_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one hash unit between the FIB insert and lookup paths.
// One transaction in flight: IDLE -> ISSUE -> WAIT (HASH_LAT cycles) -> RESP -> IDLE.
module hash_arbiter #(
  parameter int HASH_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_req,
  input  logic [63:0] ins_prefix,
  input  logic [5:0]  ins_len,
  output logic        ins_gnt,
  output logic        ins_done,
  input  logic        lkp_req,
  input  logic [63:0] lkp_prefix,
  input  logic [5:0]  lkp_len,
  output logic        lkp_gnt,
  output logic        lkp_done,
  output logic [9:0]  hash_out,
  output logic [63:0] hu_prefix,
  output logic [9:0]  hu_len,
  output logic        hu_valid,
  input  logic [9:0]  hu_value,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(HASH_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wait_cnt;
  logic        owner_lkp;
  logic [63:0] prefix_q;
  logic [5:0]  len_q;
  logic        req_any;
  logic        win_lkp;
  logic        accept;
  logic        wait_last;

  // owner_lkp doubles as the round-robin pointer: it names the last winner.
  always_comb begin
    req_any   = ins_req | lkp_req;
    win_lkp   = lkp_req & (~ins_req | ~owner_lkp);
    accept    = (state == IDLE) & req_any;
    wait_last = (state == WAIT) & (wait_cnt == 3'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ins_gnt   = 1'b0;
    lkp_gnt   = 1'b0;
    ins_done  = 1'b0;
    lkp_done  = 1'b0;
    hu_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        hu_valid  = 1'b1;
        ins_gnt   = ~owner_lkp;
        lkp_gnt   = owner_lkp;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == 3'd0) state_nxt = RESP;
      end
      RESP: begin
        ins_done  = ~owner_lkp;
        lkp_done  = owner_lkp;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= 3'd0;
      owner_lkp <= 1'b0;
    end else begin
      if (accept) begin
        owner_lkp <= win_lkp;
      end
      if (state == ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  // Operands stay on the hash-unit port until the next accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prefix_q <= 64'd0;
      len_q    <= 6'd0;
      hash_out <= 10'd0;
    end else begin
      if (accept) begin
        prefix_q <= win_lkp ? lkp_prefix : ins_prefix;
        len_q    <= win_lkp ? lkp_len : ins_len;
      end
      if (wait_last) begin
        hash_out <= hu_value;
      end
    end
  end

  always_comb begin
    hu_prefix = prefix_q;
    hu_len    = {4'b0000, len_q};
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_hash_arbiter.sv
// Scoreboard bench for hash_arbiter: one instance with HASH_LAT=1, one with HASH_LAT=5,
// each fed by a behavioural hash unit with the matching latency.
module tb_hash_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct {
    bit         lkp;
    logic [9:0] hash;
    int         gcyc;
    int         dcyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea;
  exp_t eb;

  logic        ins_req_a, lkp_req_a, ins_gnt_a, ins_done_a, lkp_gnt_a, lkp_done_a;
  logic        hu_valid_a, busy_a;
  logic [63:0] ins_prefix_a, lkp_prefix_a, hu_prefix_a;
  logic [5:0]  ins_len_a, lkp_len_a;
  logic [9:0]  hash_out_a, hu_len_a, hu_value_a;

  logic        ins_req_b, lkp_req_b, ins_gnt_b, ins_done_b, lkp_gnt_b, lkp_done_b;
  logic        hu_valid_b, busy_b;
  logic [63:0] ins_prefix_b, lkp_prefix_b, hu_prefix_b;
  logic [5:0]  ins_len_b, lkp_len_b;
  logic [9:0]  hash_out_b, hu_len_b, hu_value_b;

  hash_arbiter #(.HASH_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .ins_req(ins_req_a), .ins_prefix(ins_prefix_a), .ins_len(ins_len_a),
    .ins_gnt(ins_gnt_a), .ins_done(ins_done_a),
    .lkp_req(lkp_req_a), .lkp_prefix(lkp_prefix_a), .lkp_len(lkp_len_a),
    .lkp_gnt(lkp_gnt_a), .lkp_done(lkp_done_a),
    .hash_out(hash_out_a), .hu_prefix(hu_prefix_a), .hu_len(hu_len_a),
    .hu_valid(hu_valid_a), .hu_value(hu_value_a), .busy(busy_a)
  );

  hash_arbiter #(.HASH_LAT(5)) dut_b (
    .clk(clk), .rst(rst),
    .ins_req(ins_req_b), .ins_prefix(ins_prefix_b), .ins_len(ins_len_b),
    .ins_gnt(ins_gnt_b), .ins_done(ins_done_b),
    .lkp_req(lkp_req_b), .lkp_prefix(lkp_prefix_b), .lkp_len(lkp_len_b),
    .lkp_gnt(lkp_gnt_b), .lkp_done(lkp_done_b),
    .hash_out(hash_out_b), .hu_prefix(hu_prefix_b), .hu_len(hu_len_b),
    .hu_valid(hu_valid_b), .hu_value(hu_value_b), .busy(busy_b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference hash; constant chosen so prefix 64'hA5 / len 8 gives 10'h155.
  function automatic logic [9:0] hfun(input logic [63:0] p, input logic [9:0] l);
    return p[9:0] ^ p[19:10] ^ p[63:54] ^ 10'(l * 10'd37) ^ 10'h0D8;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Hash units: result appears HASH_LAT cycles after hu_valid, junk otherwise.
  logic [9:0] hpipe_a;
  logic [9:0] hpipe_b [5];

  always @(posedge clk) begin
    hpipe_a <= hu_valid_a ? hfun(hu_prefix_a, hu_len_a) : 10'($urandom);
    hpipe_b[0] <= hu_valid_b ? hfun(hu_prefix_b, hu_len_b) : 10'($urandom);
    for (int i = 1; i < 5; i++) hpipe_b[i] <= hpipe_b[i-1];
  end

  assign hu_value_a = hpipe_a;
  assign hu_value_b = hpipe_b[4];

  always @(negedge clk) begin
    if (ins_gnt_a || lkp_gnt_a) begin
      chk("a_gnt_expected", 64'(sb_a.size() != 0), 64'd1);
      if (sb_a.size() != 0) begin
        chk("a_gnt_owner", {62'd0, ins_gnt_a, lkp_gnt_a}, sb_a[0].lkp ? 64'd1 : 64'd2);
        chk("a_gnt_cycle", 64'(cyc), 64'(sb_a[0].gcyc));
      end
    end
    if (ins_done_a || lkp_done_a) begin
      chk("a_done_expected", 64'(sb_a.size() != 0), 64'd1);
      if (sb_a.size() != 0) begin
        ea = sb_a.pop_front();
        chk("a_done_owner", {62'd0, ins_done_a, lkp_done_a}, ea.lkp ? 64'd1 : 64'd2);
        chk("a_done_cycle", 64'(cyc), 64'(ea.dcyc));
        chk("a_hash_out", 64'(hash_out_a), 64'(ea.hash));
      end
    end
  end

  always @(negedge clk) begin
    if (ins_gnt_b || lkp_gnt_b) begin
      chk("b_gnt_expected", 64'(sb_b.size() != 0), 64'd1);
      if (sb_b.size() != 0) begin
        chk("b_gnt_owner", {62'd0, ins_gnt_b, lkp_gnt_b}, sb_b[0].lkp ? 64'd1 : 64'd2);
        chk("b_gnt_cycle", 64'(cyc), 64'(sb_b[0].gcyc));
      end
    end
    if (ins_done_b || lkp_done_b) begin
      chk("b_done_expected", 64'(sb_b.size() != 0), 64'd1);
      if (sb_b.size() != 0) begin
        eb = sb_b.pop_front();
        chk("b_done_owner", {62'd0, ins_done_b, lkp_done_b}, eb.lkp ? 64'd1 : 64'd2);
        chk("b_done_cycle", 64'(cyc), 64'(eb.dcyc));
        chk("b_hash_out", 64'(hash_out_b), 64'(eb.hash));
      end
    end
  end

  task automatic chk_a_zero(input string tag);
    chk({tag, "_hash_out"}, 64'(hash_out_a), 64'd0);
    chk({tag, "_hu_prefix"}, hu_prefix_a, 64'd0);
    chk({tag, "_hu_len"}, 64'(hu_len_a), 64'd0);
    chk({tag, "_pulses"}, 64'({ins_gnt_a, ins_done_a, lkp_gnt_a, lkp_done_a, hu_valid_a, busy_a}), 64'd0);
  endtask

  task automatic chk_b_zero(input string tag);
    chk({tag, "_hash_out"}, 64'(hash_out_b), 64'd0);
    chk({tag, "_hu_prefix"}, hu_prefix_b, 64'd0);
    chk({tag, "_hu_len"}, 64'(hu_len_b), 64'd0);
    chk({tag, "_pulses"}, 64'({ins_gnt_b, ins_done_b, lkp_gnt_b, lkp_done_b, hu_valid_b, busy_b}), 64'd0);
  endtask

  initial begin
    int e;
    rst = 1'b1;
    {ins_req_a, lkp_req_a, ins_req_b, lkp_req_b} = 4'b0000;
    ins_prefix_a = 64'd0; lkp_prefix_a = 64'd0; ins_len_a = 6'd0; lkp_len_a = 6'd0;
    ins_prefix_b = 64'd0; lkp_prefix_b = 64'd0; ins_len_b = 6'd0; lkp_len_b = 6'd0;
    #3 rst = 1'b0;
    tick(2);
    chk_a_zero("rst_a");
    chk_b_zero("rst_b");
    rst = 1'b1;
    tick(1);

    // Single insert with HASH_LAT=1
    ins_req_a = 1'b1; ins_prefix_a = 64'hA5; ins_len_a = 6'd8;
    e = cyc + 1;
    sb_a.push_back('{1'b0, 10'h155, e, e + 2});
    tick(1);
    chk("s1_hu_valid", 64'(hu_valid_a), 64'd1);
    chk("s1_hu_len", 64'(hu_len_a), 64'd8);
    chk("s1_hu_prefix", hu_prefix_a, 64'hA5);
    chk("s1_busy", 64'(busy_a), 64'd1);
    ins_req_a = 1'b0;
    tick(1);
    chk("s1_hu_valid_wait", 64'(hu_valid_a), 64'd0);
    chk("s1_hu_prefix_hold", hu_prefix_a, 64'hA5);
    tick(2);
    chk("s1_hash_hold", 64'(hash_out_a), 64'h155);
    chk("s1_idle", 64'(busy_a), 64'd0);

    // Lone lookup moves the pointer to lkp before the reset below
    lkp_req_a = 1'b1; lkp_prefix_a = 64'h3C; lkp_len_a = 6'd12;
    e = cyc + 1;
    sb_a.push_back('{1'b1, hfun(64'h3C, 10'd12), e, e + 2});
    tick(1);
    lkp_req_a = 1'b0;
    tick(3);

    // Tie right after reset: lkp first, ins four cycles later
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    ins_req_a = 1'b1; ins_prefix_a = 64'hFEDC_BA98_7654_3210; ins_len_a = 6'd0;
    lkp_req_a = 1'b1; lkp_prefix_a = 64'h0123_4567_89AB_CDEF; lkp_len_a = 6'd24;
    e = cyc + 1;
    sb_a.push_back('{1'b1, hfun(lkp_prefix_a, {4'b0, lkp_len_a}), e, e + 2});
    sb_a.push_back('{1'b0, hfun(ins_prefix_a, {4'b0, ins_len_a}), e + 4, e + 6});
    tick(1);
    chk("s2_hu_prefix_lkp", hu_prefix_a, 64'h0123_4567_89AB_CDEF);
    chk("s2_hu_len_lkp", 64'(hu_len_a), 64'd24);
    tick(2);
    lkp_req_a = 1'b0;
    tick(2);
    chk("s2_hu_prefix_ins", hu_prefix_a, 64'hFEDC_BA98_7654_3210);
    chk("s2_hu_len_zero", 64'(hu_len_a), 64'd0);
    ins_req_a = 1'b0;
    tick(3);
    chk("s2_hash_hold", 64'(hash_out_a), 64'(hfun(64'hFEDC_BA98_7654_3210, 10'd0)));

    // Both held across several transactions: strict alternation
    ins_req_a = 1'b1; lkp_req_a = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        sb_a.push_back('{1'b1, hfun(lkp_prefix_a, {4'b0, lkp_len_a}), e + 4*k, e + 4*k + 2});
      else
        sb_a.push_back('{1'b0, hfun(ins_prefix_a, {4'b0, ins_len_a}), e + 4*k, e + 4*k + 2});
    end
    tick(13);
    ins_req_a = 1'b0; lkp_req_a = 1'b0;
    tick(6);
    chk("s3_idle", 64'(busy_a), 64'd0);

    // Reset during WAIT: no done, everything cleared at once
    ins_req_a = 1'b1; ins_prefix_a = 64'h0000_0000_DEAD_BEEF; ins_len_a = 6'd63;
    e = cyc + 1;
    sb_a.push_back('{1'b0, hfun(ins_prefix_a, 10'd63), e, e + 2});
    tick(1);
    ins_req_a = 1'b0;
    tick(1);
    rst = 1'b0;
    #1;
    chk_a_zero("s4_rst");
    void'(sb_a.pop_front());
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("s4_hash_after", 64'(hash_out_a), 64'd0);
    lkp_req_a = 1'b1; lkp_prefix_a = 64'h1; lkp_len_a = 6'd1;
    e = cyc + 1;
    sb_a.push_back('{1'b1, hfun(64'h1, 10'd1), e, e + 2});
    tick(1);
    lkp_req_a = 1'b0;
    tick(3);
    chk("s4_recover_hash", 64'(hash_out_a), 64'(hfun(64'h1, 10'd1)));

    // HASH_LAT=5 lookup: done 7 cycles after sampling, busy for 7 cycles
    lkp_req_b = 1'b1; lkp_prefix_b = 64'hCAFE_F00D_1234_5678; lkp_len_b = 6'd48;
    e = cyc + 1;
    sb_b.push_back('{1'b1, hfun(lkp_prefix_b, 10'd48), e, e + 6});
    chk("s5_busy_pre", 64'(busy_b), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (k == 0) lkp_req_b = 1'b0;
      chk("s5_busy", 64'(busy_b), (k < 7) ? 64'd1 : 64'd0);
    end
    chk("s5_hash_hold", 64'(hash_out_b), 64'(hfun(64'hCAFE_F00D_1234_5678, 10'd48)));

    // HASH_LAT=5 reset mid-WAIT: the late hu_value must not land
    ins_req_b = 1'b1; ins_prefix_b = 64'h5555_AAAA_5555_AAAA; ins_len_b = 6'd5;
    e = cyc + 1;
    sb_b.push_back('{1'b0, hfun(ins_prefix_b, 10'd5), e, e + 6});
    tick(1);
    ins_req_b = 1'b0;
    tick(2);
    rst = 1'b0;
    #1;
    chk_b_zero("s6_rst");
    void'(sb_b.pop_front());
    tick(1);
    rst = 1'b1;
    tick(3);
    chk("s6_late_ignored", 64'(hash_out_b), 64'd0);
    chk("s6_idle", 64'(busy_b), 64'd0);
    ins_req_b = 1'b1; lkp_req_b = 1'b1;
    lkp_prefix_b = 64'h0F0F_0F0F_0F0F_0F0F; lkp_len_b = 6'd32;
    e = cyc + 1;
    sb_b.push_back('{1'b1, hfun(lkp_prefix_b, 10'd32), e, e + 6});
    sb_b.push_back('{1'b0, hfun(ins_prefix_b, 10'd5), e + 8, e + 14});
    tick(1);
    lkp_req_b = 1'b0;
    tick(8);
    ins_req_b = 1'b0;
    tick(7);
    chk("s6_hash_final", 64'(hash_out_b), 64'(hfun(64'h5555_AAAA_5555_AAAA, 10'd5)));

    tick(2);
    chk("a_sb_drained", 64'(sb_a.size()), 64'd0);
    chk("b_sb_drained", 64'(sb_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
